// File: rtl/snn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : snn_pkg                                                     |
// | Description: Shared spiking-network definitions used by the MAC array,   |
// |              the spike encoder and the LIF neuron: default datapath      |
// |              widths, neuron state encoding and the membrane saturation   |
// |              constant.                                                   |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package snn_pkg;

  // Default datapath widths
  localparam int c_SUM_W = 21;   // unsigned MAC result per timestep
  localparam int c_MEM_W = 24;   // unsigned membrane potential
  localparam int c_CNT_W = 16;   // saturating spike counter

  // Largest representable membrane value at the default width
  localparam logic [c_MEM_W-1:0] c_MEM_SAT_MAX = {c_MEM_W{1'b1}};

  // Neuron operating state. REFRACT is only reachable in builds with the
  // refractory feature enabled.
  typedef enum logic [0:0] {
    INTEG   = 1'b0,
    REFRACT = 1'b1
  } lif_state_t;

endpackage : snn_pkg
`default_nettype wire

// File: rtl/lif_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lif_sat_add                                                 |
// | Description: Purely combinational MEM_W-bit saturating unsigned adder.   |
// |              Adds the leaked membrane value to the zero-extended MAC     |
// |              sum and clamps the result at all-ones instead of wrapping.  |
// | Ports      : i_a   [MEM_W-1:0] leaked membrane potential                 |
// |              i_b   [SUM_W-1:0] MAC sum (unsigned)                        |
// |              o_sum [MEM_W-1:0] saturated sum                             |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lif_sat_add
  import snn_pkg::*;
#(
  parameter int MEM_W = c_MEM_W,
  parameter int SUM_W = c_SUM_W   // must not exceed MEM_W
) (
  input  logic [MEM_W-1:0] i_a,
  input  logic [SUM_W-1:0] i_b,
  output logic [MEM_W-1:0] o_sum
);

  // One extra bit captures the carry out of the MEM_W-bit add.
  logic [MEM_W:0] w_full;

  assign w_full = {1'b0, i_a} + {{(MEM_W + 1 - SUM_W){1'b0}}, i_b};
  assign o_sum  = w_full[MEM_W] ? {MEM_W{1'b1}} : w_full[MEM_W-1:0];

endmodule : lif_sat_add
`default_nettype wire

// File: rtl/lif_neuron.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : lif_neuron                                                  |
// | Description: Leaky integrate-and-fire neuron. Once per timestep          |
// |              (sumValid pulse) the membrane is leaked by v>>LEAK_SHIFT,   |
// |              the MAC sum is added with saturation, and the result is     |
// |              compared to threshIn. Crossing fires a one-cycle spike and  |
// |              resets the membrane.                                        |
// | Options    : LIF_REFRACTORY_EN - when defined, a spike is followed by    |
// |              REFRAC_STEPS timesteps during which sums are discarded.     |
// | Ports      : clk          rising-edge clock                              |
// |              rst_n        asynchronous active-low reset                  |
// |              sumIn        [SUM_W] MAC sum for the current timestep       |
// |              sumValid     one-cycle timestep strobe                      |
// |              threshIn     [MEM_W] firing threshold                       |
// |              clearIn      synchronous clear of all neuron state          |
// |              spikeOut     one-cycle spike pulse                          |
// |              membraneOut  [MEM_W] membrane potential register            |
// |              refractory   high while in the refractory state             |
// |              spikeCount   [CNT_W] saturating spike counter               |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module lif_neuron
  import snn_pkg::*;
#(
  parameter int SUM_W        = c_SUM_W,
  parameter int MEM_W        = c_MEM_W,
  parameter int LEAK_SHIFT   = 4,
  parameter int V_RESET      = 0,
  parameter int REFRAC_STEPS = 2,
  parameter int CNT_W        = c_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SUM_W-1:0] sumIn,
  input  logic             sumValid,
  input  logic [MEM_W-1:0] threshIn,
  input  logic             clearIn,
  output logic             spikeOut,
  output logic [MEM_W-1:0] membraneOut,
  output logic             refractory,
  output logic [CNT_W-1:0] spikeCount
);

  localparam logic [MEM_W-1:0] c_V_RESET = MEM_W'(V_RESET);

  // ---------------------------------------------------------------------
  // Registered neuron state
  // ---------------------------------------------------------------------
  logic [MEM_W-1:0] r_v;
  logic             r_spike;
  logic [CNT_W-1:0] r_count;

  logic [MEM_W-1:0] w_v_next;
  logic             w_spike_next;
  logic [CNT_W-1:0] w_count_next;

  // Datapath: leak, saturating add, threshold compare
  logic [MEM_W-1:0] w_leaked;
  logic [MEM_W-1:0] w_v_sum;
  logic             w_cross;
  logic             w_in_integ;

  // With LEAK_SHIFT = 0 this is v - v = 0, i.e. the old membrane is dropped.
  assign w_leaked = r_v - (r_v >> LEAK_SHIFT);

  lif_sat_add #(
    .MEM_W (MEM_W),
    .SUM_W (SUM_W)
  ) u_sat_add (
    .i_a   (w_leaked),
    .i_b   (sumIn),
    .o_sum (w_v_sum)
  );

  assign w_cross = (w_v_sum >= threshIn);

`ifdef LIF_REFRACTORY_EN
  // ---------------------------------------------------------------------
  // Refractory FSM: counts timesteps (not clock cycles) after a spike.
  // ---------------------------------------------------------------------
  localparam int                c_RC_W    = (REFRAC_STEPS > 1) ? $clog2(REFRAC_STEPS + 1) : 1;
  localparam logic [c_RC_W-1:0] c_RC_LOAD = c_RC_W'(REFRAC_STEPS);
  localparam logic [c_RC_W-1:0] c_RC_LAST = c_RC_W'(1);

  lif_state_t        r_state;
  lif_state_t        w_state_next;
  logic [c_RC_W-1:0] r_rcnt;
  logic [c_RC_W-1:0] w_rcnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INTEG;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_rcnt  <= w_rcnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_rcnt_next  = r_rcnt;
    if (clearIn) begin
      w_state_next = INTEG;
      w_rcnt_next  = '0;
    end else if (sumValid) begin
      case (r_state)
        INTEG: begin
          if (w_cross && (REFRAC_STEPS > 0)) begin
            w_state_next = REFRACT;
            w_rcnt_next  = c_RC_LOAD;
          end
        end
        REFRACT: begin
          w_rcnt_next = r_rcnt - 1'b1;
          if (r_rcnt == c_RC_LAST) begin
            w_state_next = INTEG;
          end
        end
        default: begin
          w_state_next = INTEG;
          w_rcnt_next  = '0;
        end
      endcase
    end
  end

  assign w_in_integ = (r_state == INTEG);
  assign refractory = (r_state == REFRACT);
`else
  // No refractory period: every timestep integrates.
  assign w_in_integ = 1'b1;
  assign refractory = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Membrane, spike and counter next-state. Clear beats a coincident
  // timestep, which is dropped entirely. While refractory the membrane
  // simply holds (it is already V_RESET after the spike).
  // ---------------------------------------------------------------------
  always_comb begin
    w_v_next     = r_v;
    w_spike_next = 1'b0;
    w_count_next = r_count;
    if (clearIn) begin
      w_v_next     = c_V_RESET;
      w_count_next = '0;
    end else if (sumValid && w_in_integ) begin
      if (w_cross) begin
        w_v_next     = c_V_RESET;
        w_spike_next = 1'b1;
        if (r_count != {CNT_W{1'b1}}) begin
          w_count_next = r_count + 1'b1;
        end
      end else begin
        w_v_next = w_v_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= c_V_RESET;
      r_spike <= 1'b0;
      r_count <= '0;
    end else begin
      r_v     <= w_v_next;
      r_spike <= w_spike_next;
      r_count <= w_count_next;
    end
  end

  assign spikeOut    = r_spike;
  assign membraneOut = r_v;
  assign spikeCount  = r_count;

endmodule : lif_neuron
`default_nettype wire

// File: tb/tb_lif_neuron.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_lif_neuron                                               |
// | Description: Self-checking bench for lif_neuron. A constant vector       |
// |              table covers the basic integrate/fire/clear sequence; hand  |
// |              sequences cover refractory, saturation, async reset and a   |
// |              zero threshold; random timesteps are compared against an    |
// |              integer reference model of the neuron.                      |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lif_neuron;
  import snn_pkg::*;

  localparam int SUM_W        = 21;
  localparam int MEM_W        = 24;
  localparam int CNT_W        = 16;
  localparam int LEAK_SHIFT   = 4;
  localparam int V_RESET      = 0;
  localparam int REFRAC_STEPS = 2;
`ifdef LIF_REFRACTORY_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif
  localparam longint VMAX = (64'sd1 <<< MEM_W) - 1;
  localparam longint CMAX = (64'sd1 <<< CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [SUM_W-1:0] sumIn = '0;
  logic             sumValid = 1'b0;
  logic [MEM_W-1:0] threshIn = '0;
  logic             clearIn = 1'b0;
  logic             spikeOut;
  logic [MEM_W-1:0] membraneOut;
  logic             refractory;
  logic [CNT_W-1:0] spikeCount;

  always #5 clk = ~clk;

  lif_neuron #(
    .SUM_W        (SUM_W),
    .MEM_W        (MEM_W),
    .LEAK_SHIFT   (LEAK_SHIFT),
    .V_RESET      (V_RESET),
    .REFRAC_STEPS (REFRAC_STEPS),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sumIn       (sumIn),
    .sumValid    (sumValid),
    .threshIn    (threshIn),
    .clearIn     (clearIn),
    .spikeOut    (spikeOut),
    .membraneOut (membraneOut),
    .refractory  (refractory),
    .spikeCount  (spikeCount)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (plain integer arithmetic) ----------
  longint m_v;
  longint m_count;
  int     m_left;     // timesteps still to be ignored after a spike
  bit     m_spike;

  task automatic model_reset();
    m_v = V_RESET; m_count = 0; m_left = 0; m_spike = 0;
  endtask

  task automatic model_step(input bit v, input longint s, input bit c, input longint t);
    longint vn;
    m_spike = 0;
    if (c) begin
      m_v = V_RESET; m_count = 0; m_left = 0;
    end else if (v) begin
      if (m_left > 0) begin
        m_left--;
      end else begin
        vn = m_v - (m_v >> LEAK_SHIFT) + s;
        if (vn > VMAX) vn = VMAX;
        if (vn >= t) begin
          m_spike = 1;
          m_v = V_RESET;
          if (m_count < CMAX) m_count++;
          if (REF_EN) m_left = REFRAC_STEPS;
        end else begin
          m_v = vn;
        end
      end
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), sample at next posedge+1.
  task automatic apply(input bit v, input longint s, input bit c, input longint t);
    sumValid = v; sumIn = SUM_W'(s); clearIn = c; threshIn = MEM_W'(t);
    @(posedge clk); #1;
    sumValid = 1'b0; clearIn = 1'b0;
    model_step(v, s, c, t);
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".spike"}, 64'(spikeOut),    64'(m_spike));
    check({tag, ".v"},     64'(membraneOut), 64'(m_v));
    check({tag, ".refr"},  64'(refractory),  64'(m_left > 0));
    check({tag, ".count"}, 64'(spikeCount),  64'(m_count));
  endtask

  task automatic step(input bit v, input longint s, input bit c, input longint t, input string tag);
    apply(v, s, c, t);
    compare_model(tag);
  endtask

  typedef struct {
    bit     valid;
    int     sum;
    bit     clr;
    int     thr;
    bit     e_spike;
    int     e_v;
    bit     e_refr;
    int     e_count;
  } vec_t;

  vec_t vecs[7];
  int   spikes_seen;

  initial begin
    // Hand-derived vectors, threshold 1000, leak v>>4.
    vecs[0] = '{1, 400,  0, 1000, 0, 400,  0,      0};
    vecs[1] = '{1, 400,  0, 1000, 0, 775,  0,      0};  // 400-25+400
    vecs[2] = '{1, 400,  0, 1000, 1, 0,    REF_EN, 1};  // 775-48+400=1127 fires
    vecs[3] = '{0, 0,    0, 1000, 0, 0,    REF_EN, 1};  // idle: all holds
    vecs[4] = '{1, 5000, 1, 1000, 0, 0,    0,      0};  // clear wins over sum
    vecs[5] = '{0, 0,    0, 1000, 0, 0,    0,      0};
    vecs[6] = '{1, 5000, 0, 1000, 1, 0,    REF_EN, 1};  // integrates from 0

    model_reset();
    #12;
    check("reset.v",     64'(membraneOut), 64'(V_RESET));
    check("reset.spike", 64'(spikeOut),    64'd0);
    check("reset.count", 64'(spikeCount),  64'd0);
    check("reset.refr",  64'(refractory),  64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 7; i++) begin
      apply(vecs[i].valid, vecs[i].sum, vecs[i].clr, vecs[i].thr);
      check($sformatf("vec%0d.spike", i), 64'(spikeOut),    64'(vecs[i].e_spike));
      check($sformatf("vec%0d.v", i),     64'(membraneOut), 64'(vecs[i].e_v));
      check($sformatf("vec%0d.refr", i),  64'(refractory),  64'(vecs[i].e_refr));
      check($sformatf("vec%0d.count", i), 64'(spikeCount),  64'(vecs[i].e_count));
    end

    // ---------------- refractory: sums discarded for REFRAC_STEPS ------------
    step(1, 0, 1, 1000, "rf.clr");
    step(1, 400, 0, 1000, "rf.a");
    step(1, 400, 0, 1000, "rf.b");
    step(1, 400, 0, 1000, "rf.fire");
    step(1, 2000, 0, 1000, "rf.s1");
    step(1, 2000, 0, 1000, "rf.s2");
    check("rf.refr_fell", 64'(refractory), 64'd0);
    step(1, 2000, 0, 1000, "rf.s3");
    check("rf.s3_spike", 64'(spikeOut), REF_EN ? 64'd1 : 64'd1);
    check("rf.count", 64'(spikeCount), REF_EN ? 64'd2 : 64'd4);

    // ---------------- saturation: clamp, fire on reaching all-ones ----------
    step(0, 0, 1, VMAX, "sat.clr");
    spikes_seen = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, 64'h1FFFFF, 0, VMAX, $sformatf("sat%0d", i));
      if (spikeOut) spikes_seen++;
    end
    check("sat.spikes", 64'(spikes_seen), 64'd1);
    check("sat.count",  64'(spikeCount),  64'd1);

    // ---------------- async reset between edges ----------------
    step(0, 0, 1, 1000, "ar.clr");
    step(1, 5000, 0, 1000, "ar.fire");
    if (REF_EN) begin
      step(1, 0, 0, 1000, "ar.r1");
      step(1, 0, 0, 1000, "ar.r2");
    end
    step(1, 400, 0, 1000, "ar.a");
    step(1, 400, 0, 1000, "ar.b");
    check("ar.v_before", 64'(membraneOut), 64'd775);
    #2 rst_n = 1'b0;
    #1;
    check("ar.v",     64'(membraneOut), 64'd0);
    check("ar.spike", 64'(spikeOut),    64'd0);
    check("ar.refr",  64'(refractory),  64'd0);
    check("ar.count", 64'(spikeCount),  64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    step(1, 400, 0, 1000, "ar.post");
    check("ar.post_v", 64'(membraneOut), 64'd400);

    // ---------------- zero threshold: every integrating step fires -----------
    step(0, 0, 1, 0, "z.clr");
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, $sformatf("z%0d", i));
      step(0, 0, 0, 0, $sformatf("z%0d.gap", i));
      check($sformatf("z%0d.gap_spike", i), 64'(spikeOut), 64'd0);
    end
    check("z.count", 64'(spikeCount), REF_EN ? 64'd2 : 64'd4);

    // ---------------- randomized timesteps vs. model ----------------
    step(0, 0, 1, 0, "rnd.clr");
    for (int i = 0; i < 400; i++) begin
      bit     v;
      bit     c;
      longint s;
      longint t;
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 40) == 0);
      s = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(0, 2097151))
                                     : longint'($urandom_range(0, 3000));
      t = ($urandom_range(0, 9) == 0) ? longint'($urandom_range(0, 16777215))
                                     : longint'($urandom_range(0, 8000));
      step(v, s, c, t, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_lif_neuron
`default_nettype wire
